// File: rtl/gba_video_pkg.sv
// Shared GBA / VGA geometry and pixel formats for the framebuffer
// read path.
package gba_video_pkg;

  localparam int GBA_W    = 240;
  localparam int GBA_H    = 160;
  localparam int FB_WORDS = GBA_W * GBA_H;
  localparam int VGA_W    = 640;
  localparam int VGA_H    = 480;
  localparam int SCALE    = 2;

  typedef struct packed {
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
  } rgb555_t;

  // Replicating the top bits maps 5'h1F to 8'hFF exactly.
  function automatic logic [23:0] rgb555_to_888(rgb555_t c);
    return {c.r, c.r[4:2], c.g, c.g[4:2], c.b, c.b[4:2]};
  endfunction

endpackage

// File: rtl/gba_scale_addr_gen.sv
// Raster tracking, scaled-window compare and incremental framebuffer
// addressing (read pipeline stage 1); advances only on i_ce.
module gba_scale_addr_gen
  import gba_video_pkg::*;
#(
  parameter int unsigned X_OFF    = 80,
  parameter int unsigned Y_OFF    = 80,
  parameter bit          SYNC_NEG = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ce,
  input  logic        i_de,
  input  logic        i_vs,
  output logic [15:0] o_rdaddr,
  output logic        o_in_win,
  output logic        o_locked
);

  localparam logic [9:0]  XLO     = 10'(X_OFF);
  localparam logic [9:0]  XHI     = 10'(X_OFF + GBA_W * SCALE);
  localparam logic [8:0]  YLO     = 9'(Y_OFF);
  localparam logic [8:0]  YHI     = 9'(Y_OFF + GBA_H * SCALE);
  localparam logic [15:0] LB_STEP = 16'(GBA_W);
  localparam logic [15:0] LB_MAX  = 16'(FB_WORDS - GBA_W);

  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [15:0] lb_q, lb_d;
  logic [7:0]  col_q, col_d;
  logic [15:0] addr_q, addr_d;
  logic        lock_q, lock_d;
  logic        de_q, vs_q, win_q;

  logic vs_act, vs_edge, de_fall;
  logic x_in, y_in, in_win;

  always_comb begin
    vs_act  = SYNC_NEG ? ~i_vs : i_vs;
    vs_edge = vs_act & ~vs_q;
    de_fall = de_q & ~i_de;
    x_in    = (x_q >= XLO) && (x_q < XHI);
    y_in    = (y_q >= YLO) && (y_q < YHI);
    in_win  = lock_q & i_de & x_in & y_in;
    lock_d  = lock_q | vs_edge;

    x_d = '0;
    if (i_de) begin
      x_d = (x_q == '1) ? x_q : x_q + 10'd1;
    end

    y_d = y_q;
    if (vs_edge) begin
      y_d = '0;
    end else if (de_fall && y_q != '1) begin
      y_d = y_q + 9'd1;
    end

    // Each source row is shown on two lines; step after the odd one.
    lb_d = lb_q;
    if (vs_edge) begin
      lb_d = '0;
    end else if (de_fall && y_in && (y_q[0] ^ YLO[0])
                 && lb_q < LB_MAX) begin
      lb_d = lb_q + LB_STEP;
    end

    col_d = col_q;
    if (!i_de) begin
      col_d = '0;
    end else if (in_win && (x_q[0] ^ XLO[0])) begin
      col_d = col_q + 8'd1;
    end

    addr_d = addr_q;
    if (in_win) begin
      addr_d = lb_q + {8'd0, col_q};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      lb_q   <= '0;
      col_q  <= '0;
      addr_q <= '0;
      lock_q <= 1'b0;
      de_q   <= 1'b0;
      vs_q   <= 1'b0;
      win_q  <= 1'b0;
    end else if (i_ce) begin
      x_q    <= x_d;
      y_q    <= y_d;
      lb_q   <= lb_d;
      col_q  <= col_d;
      addr_q <= addr_d;
      lock_q <= lock_d;
      de_q   <= i_de;
      vs_q   <= vs_act;
      win_q  <= in_win;
    end
  end

  assign o_rdaddr = addr_q;
  assign o_in_win = win_q;
  assign o_locked = lock_q;

endmodule

// File: rtl/gba_fb_scaler.sv
// Framebuffer read stage: 2x scaled GBA image centred in 640x480.
// Stage 1 is in gba_scale_addr_gen; stage 2 and colour are here.
module gba_fb_scaler
  import gba_video_pkg::*;
#(
  parameter int unsigned X_OFF      = 80,
  parameter int unsigned Y_OFF      = 80,
  parameter logic [23:0] BORDER_RGB = 24'h000000,
  parameter bit          SYNC_NEG   = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ce,
  input  logic        i_de,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic [14:0] i_ram_q,
  output logic [15:0] o_rdaddr,
  output logic        o_de,
  output logic        o_hs,
  output logic        o_vs,
  output logic [23:0] o_rgb,
  output logic        o_locked
);

  localparam logic SYNC_IDLE = SYNC_NEG;

  logic        win_d1;
  logic        de_d1_q, hs_d1_q, vs_d1_q;
  logic        de_q, hs_q, vs_q;
  logic [23:0] rgb_q, rgb_d;

  gba_scale_addr_gen #(
    .X_OFF    (X_OFF),
    .Y_OFF    (Y_OFF),
    .SYNC_NEG (SYNC_NEG)
  ) u_addr (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_ce     (i_ce),
    .i_de     (i_de),
    .i_vs     (i_vs),
    .o_rdaddr (o_rdaddr),
    .o_in_win (win_d1),
    .o_locked (o_locked)
  );

  // i_ram_q already holds the word for o_rdaddr by the next i_ce.
  always_comb begin
    rgb_d = '0;
    unique case (1'b1)
      !de_d1_q:           rgb_d = '0;
      de_d1_q &&  win_d1: rgb_d = rgb555_to_888(rgb555_t'(i_ram_q));
      de_d1_q && !win_d1: rgb_d = BORDER_RGB;
      default:            rgb_d = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      de_d1_q <= 1'b0;
      hs_d1_q <= SYNC_IDLE;
      vs_d1_q <= SYNC_IDLE;
      de_q    <= 1'b0;
      hs_q    <= SYNC_IDLE;
      vs_q    <= SYNC_IDLE;
      rgb_q   <= '0;
    end else if (i_ce) begin
      de_d1_q <= i_de;
      hs_d1_q <= i_hs;
      vs_d1_q <= i_vs;
      de_q    <= de_d1_q;
      hs_q    <= hs_d1_q;
      vs_q    <= vs_d1_q;
      rgb_q   <= rgb_d;
    end
  end

  assign o_de  = de_q;
  assign o_hs  = hs_q;
  assign o_vs  = vs_q;
  assign o_rgb = rgb_q;

endmodule
